// File: rtl/pb_irq_scheduler.sv
// pb_irq_scheduler: interrupt scheduler that sits in front of a small
// port-mapped processor.
//
// Each source's rising edge latches a pending bit. An enable mask gates
// arbitration. One interrupt at a time is granted and followed from request
// through acknowledge to end-of-interrupt.
//
// Build option: define PB_IRQ_RR_EN for round-robin arbitration. Without it,
// fixed priority applies and the lowest index wins.
//
// state      | meaning
// ST_IDLE    | nothing granted; arbitrate pending & mask every cycle
// ST_REQ     | interrupt_req_o high, waiting for interrupt_ack_i
// ST_SERVICE | handler running, waiting for an EOI port write
module pb_irq_scheduler #(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] MASK_PORT = 8'h10,
  parameter logic [7:0] EOI_PORT  = 8'h20,
  parameter logic [7:0] STAT_PORT = 8'h40
) (
  input  logic               clk_i,
  input  logic               cpu_rst_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [7:0]         port_id_i,
  input  logic [7:0]         out_port_i,
  input  logic               write_strobe_i,
  input  logic               interrupt_ack_i,
  output logic               interrupt_req_o,
  output logic [7:0]         rd_data_o,
  output logic [2:0]         irq_id_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               req_q, req_d;
  logic [2:0]         irq_id_q, irq_id_d;
  logic [7:0]         rd_data_q, rd_data_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] grant_clr;
  logic [2:0]         winner;
  logic               found;
  logic               mask_wr;
  logic               eoi_wr;
  logic [7:0]         stat_word;
  logic               unused_data;

`ifdef PB_IRQ_RR_EN
  logic [2:0] ptr_q, ptr_d;
  int         best;

  // Distance of source i from the round-robin pointer, wrapping at NUM_SRC.
  function automatic int rr_dist(input int i, input logic [2:0] p);
    int d;
    d = i - int'(p);
    if (d < 0) d = d + NUM_SRC;
    return d;
  endfunction
`endif

  // Only the low NUM_SRC data bits matter for the mask.
  assign unused_data = ^out_port_i;

  // Pick a winner among enabled pending sources.
  always_comb begin
    cand   = pending_q & mask_q;
    found  = |cand;
    winner = '0;
`ifdef PB_IRQ_RR_EN
    best = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i] && (rr_dist(i, ptr_q) < best)) begin
        best   = rr_dist(i, ptr_q);
        winner = 3'(i);
      end
    end
`else
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) winner = 3'(i);
    end
`endif
  end

  // Status byte layout depends on how many sources there are.
  generate
    if (NUM_SRC <= 5) begin : g_stat_small
      assign stat_word = 8'({pending_q, irq_id_q});
    end else begin : g_stat_large
      assign stat_word = 8'({busy_o, pending_q});
    end
  endgenerate

  // Next-state logic: edge detection, pending, mask, FSM and read data.
  always_comb begin
    src_d     = irq_src_i;
    prev_d    = src_q;
    rise      = src_q & ~prev_q;
    mask_wr   = write_strobe_i && (port_id_i == MASK_PORT);
    eoi_wr    = write_strobe_i && (port_id_i == EOI_PORT);
    mask_d    = mask_wr ? out_port_i[NUM_SRC-1:0] : mask_q;
    state_d   = state_q;
    req_d     = req_q;
    irq_id_d  = irq_id_q;
    grant_clr = '0;
`ifdef PB_IRQ_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            grant_clr[i] = (winner == 3'(i));
          end
          irq_id_d = winner;
          req_d    = 1'b1;
          state_d  = ST_REQ;
`ifdef PB_IRQ_RR_EN
          ptr_d    = (winner == 3'(NUM_SRC - 1)) ? 3'd0 : winner + 3'd1;
`endif
        end
      end
      ST_REQ: begin
        if (interrupt_ack_i) begin
          req_d   = 1'b0;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi_wr) state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    // A new rise on the granted source survives the clear.
    pending_d = (pending_q & ~grant_clr) | rise;
    rd_data_d = (port_id_i == STAT_PORT) ? stat_word : rd_data_q;
  end

  // All state registers; reset has priority over everything.
  always_ff @(posedge clk_i) begin
    if (cpu_rst_i) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      req_q     <= 1'b0;
      irq_id_q  <= '0;
      rd_data_q <= '0;
`ifdef PB_IRQ_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      req_q     <= req_d;
      irq_id_q  <= irq_id_d;
      rd_data_q <= rd_data_d;
`ifdef PB_IRQ_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign interrupt_req_o = req_q;
  assign irq_id_o        = irq_id_q;
  assign rd_data_o       = rd_data_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule
